// File: rtl/accel_pkg.sv
// accel_pkg: shared FSM/error encodings and the rotate-left helper for the accelerator wrapper.
package accel_pkg;

    typedef enum logic [1:0] {ACC_IDLE, ACC_RUN, ACC_WRITE, ACC_DONE} acc_state_t;
    typedef enum logic [1:0] {ACC_ERR_NONE, ACC_ERR_LEN, ACC_ERR_ADDR, ACC_ERR_BUSY} acc_error_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

endpackage

// File: rtl/accel_ctx_mem.sv
// accel_ctx_mem: all-context scratchpad, one port, byte-enabled writes, combinational read.
module accel_ctx_mem #(
    parameter int WORDS = 48,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/accel_wrapper_mc.sv
// accel_wrapper_mc: multi-context rotate-XOR digest engine behind a bus scratchpad port.
// Optional ACCEL_BUS_LOCK_EN: bus accesses while busy raise ACC_ERR_BUSY (otherwise dropped silently).
module accel_wrapper_mc
    import accel_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 16,
    parameter int OUT_WORDS      = 8,
    parameter int NUM_CTX        = 2,
    localparam int CW            = $clog2(NUM_CTX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CW-1:0]             ctx_sel,
    input  logic                      start,
    output logic                      done,
    input  logic [5:0]                output_length_byte,
    output acc_state_t                accel_state,
    output acc_error_t                accel_error,
    input  logic                      mem_en,
    input  logic                      mem_we,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [3:0]                mem_be,
    input  logic [MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic [MEM_DATA_WIDTH-1:0] mem_rdata
);

    localparam int CTX_WORDS = MEM_DEPTH + OUT_WORDS;
    localparam int AW        = $clog2(CTX_WORDS);
    localparam int TW        = $clog2(NUM_CTX * CTX_WORDS);

    acc_state_t    state, state_d;
    acc_error_t    err_d, new_err;
    logic [CW-1:0] ctx_q, ram_ctx;
    logic [5:0]    len_q;
    logic [AW-1:0] cnt, word, ram_word;
    logic [31:0]   acc, rot, res_word, ram_rdata, ram_wdata;
    logic [TW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic          busy, addr_ok, len_ok, last, accept, ram_we;
    logic          unused_addr;

    assign unused_addr = ^mem_addr[MEM_ADDR_WIDTH-1:AW];
    assign word        = mem_addr[AW-1:0];
    assign busy        = state == ACC_RUN || state == ACC_WRITE;
    assign addr_ok     = word < AW'(CTX_WORDS);
    assign len_ok      = output_length_byte != 6'd0 && output_length_byte <= 6'(4 * OUT_WORDS);
    assign accept      = state == ACC_IDLE && start;
    assign last        = cnt == (state == ACC_RUN ? AW'(MEM_DEPTH - 1) : AW'(OUT_WORDS - 1));
    assign done        = state == ACC_DONE;
    assign accel_state = state;

    always_comb begin
        state_d = state;
        unique case (state)
            ACC_IDLE:  state_d = start ? (len_ok ? ACC_RUN : ACC_DONE) : ACC_IDLE;
            ACC_RUN:   state_d = last ? ACC_WRITE : ACC_RUN;
            ACC_WRITE: state_d = last ? ACC_DONE : ACC_WRITE;
            ACC_DONE:  state_d = start ? ACC_DONE : ACC_IDLE;
        endcase
    end

    // Result bytes past the requested length are written as zero.
    always_comb begin
        rot      = rotl(acc, 5'(cnt));
        res_word = rot;
        for (int b = 0; b < 4; b++)
            if (int'(cnt) * 4 + b >= int'(len_q)) res_word[8*b +: 8] = 8'h00;
    end

    always_comb begin
        ram_ctx   = busy ? ctx_q : ctx_sel;
        ram_word  = state == ACC_RUN ? cnt : state == ACC_WRITE ? AW'(MEM_DEPTH) + cnt : word;
        ram_we    = state == ACC_WRITE || (!busy && mem_en && mem_we && addr_ok);
        ram_be    = busy ? 4'hF : mem_be;
        ram_wdata = busy ? res_word : mem_wdata;
        ram_addr  = TW'(ram_ctx) * TW'(CTX_WORDS) + TW'(ram_word);
    end

    accel_ctx_mem #(.WORDS(NUM_CTX * CTX_WORDS), .AW(TW)) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Sticky error: a valid start clears it, then the first new error of the cycle lands.
    always_comb begin
        new_err = ACC_ERR_NONE;
        if (accept && !len_ok) new_err = ACC_ERR_LEN;
        if (mem_en && !busy && !addr_ok) new_err = ACC_ERR_ADDR;
`ifdef ACCEL_BUS_LOCK_EN
        if (mem_en && busy) new_err = ACC_ERR_BUSY;
`endif
        err_d = (accept && len_ok) ? ACC_ERR_NONE : accel_error;
        err_d = err_d == ACC_ERR_NONE ? new_err : err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC_IDLE;
            accel_error <= ACC_ERR_NONE;
            mem_rdata   <= '0;
            acc         <= '0;
            cnt         <= '0;
            ctx_q       <= '0;
            len_q       <= '0;
        end else begin
            state       <= state_d;
            accel_error <= err_d;
            if (mem_en) mem_rdata <= (!busy && addr_ok) ? ram_rdata : '0;
            if (accept) begin
                ctx_q <= ctx_sel;
                len_q <= output_length_byte;
                cnt   <= '0;
                if (len_ok) acc <= '0;
            end
            if (state == ACC_RUN) acc <= rotl(acc, 5'd1) ^ ram_rdata;
            if (busy) cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_accel_wrapper_mc.sv
// tb_accel_wrapper_mc: directed self-checking bench for accel_wrapper_mc (covers ACCEL_BUS_LOCK_EN both ways).
module tb_accel_wrapper_mc;
    import accel_pkg::*;

    logic        clk = 0, rst_n = 0, ctx_sel = 0, start = 0, done;
    logic [5:0]  output_length_byte = 0;
    acc_state_t  accel_state;
    acc_error_t  accel_error;
    logic        mem_en = 0, mem_we = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
    logic [3:0]  mem_be = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    accel_wrapper_mc dut (
        .clk(clk), .rst_n(rst_n), .ctx_sel(ctx_sel), .start(start), .done(done),
        .output_length_byte(output_length_byte), .accel_state(accel_state),
        .accel_error(accel_error), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic bus_write(input int c, input int a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        ctx_sel = 1'(c); mem_en = 1; mem_we = 1; mem_addr = 32'(a); mem_wdata = d; mem_be = be;
        @(negedge clk);
        mem_en = 0; mem_we = 0;
    endtask

    task automatic bus_read(input int c, input int a, output logic [31:0] d);
        @(negedge clk);
        ctx_sel = 1'(c); mem_en = 1; mem_we = 0; mem_addr = 32'(a);
        @(negedge clk);
        mem_en = 0;
        d = mem_rdata;
    endtask

    // cyc counts clock edges from the one sampling start up to the one raising done.
    task automatic run(input int c, input int len, output int cyc);
        @(negedge clk);
        ctx_sel = 1'(c); output_length_byte = 6'(len); start = 1; cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!done && cyc < 100);
        @(negedge clk); start = 0;
        @(negedge clk);
    endtask

    task automatic load_ctx(input int c, input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < 16; i++) bus_write(c, i, i == 0 ? w0 : i == 1 ? w1 : 32'h0, 4'hF);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 4;
        if (accel_state !== ACC_IDLE) begin failures++; $display("FAIL reset_state got %0d exp %0d", accel_state, ACC_IDLE); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        if (accel_error !== ACC_ERR_NONE) begin failures++; $display("FAIL reset_err got %0d exp 0", accel_error); end
        if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h exp 0", mem_rdata); end
        rst_n = 1;
        load_ctx(0, 32'h5555_5555, 32'h8888_8888);
        @(negedge clk); output_length_byte = 8; start = 1;
        repeat (6) @(posedge clk);
        @(negedge clk); rst_n = 0; #1;
        checks += 3;
        if (accel_state !== ACC_IDLE) begin failures++; $display("FAIL midrun_reset_state got %0d exp %0d", accel_state, ACC_IDLE); end
        if (done !== 1'b0) begin failures++; $display("FAIL midrun_reset_done got %b exp 0", done); end
        if (accel_error !== ACC_ERR_NONE) begin failures++; $display("FAIL midrun_reset_err got %0d exp 0", accel_error); end
        start = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_digest();
        logic [31:0] exp_w [8] = '{32'h8888_8888, 32'h1111_1111, 0, 0, 0, 0, 0, 0};
        logic [31:0] d;
        int cyc;
        run(0, 8, cyc);
        checks += 2;
        if (cyc !== 25) begin failures++; $display("FAIL digest_latency got %0d exp 25", cyc); end
        if (accel_error !== ACC_ERR_NONE) begin failures++; $display("FAIL digest_err got %0d exp 0", accel_error); end
        for (int k = 0; k < 8; k++) begin
            bus_read(0, 16 + k, d);
            checks++;
            if (d !== exp_w[k]) begin failures++; $display("FAIL digest_w%0d got %h exp %h", 16 + k, d, exp_w[k]); end
        end
    endtask

    task automatic test_partial_length();
        logic [31:0] d;
        int cyc;
        run(0, 5, cyc);
        bus_read(0, 16, d);
        checks++;
        if (d !== 32'h8888_8888) begin failures++; $display("FAIL len5_w16 got %h exp 88888888", d); end
        bus_read(0, 17, d);
        checks++;
        if (d !== 32'h0000_0011) begin failures++; $display("FAIL len5_w17 got %h exp 00000011", d); end
        bus_read(0, 18, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL len5_w18 got %h exp 0", d); end
    endtask

    task automatic test_len_error();
        logic [31:0] d;
        int cyc;
        int lens [2] = '{0, 40};
        foreach (lens[i]) begin
            run(0, lens[i], cyc);
            checks += 2;
            if (cyc !== 1) begin failures++; $display("FAIL lenerr%0d_latency got %0d exp 1", lens[i], cyc); end
            if (accel_error !== ACC_ERR_LEN) begin failures++; $display("FAIL lenerr%0d_err got %0d exp %0d", lens[i], accel_error, ACC_ERR_LEN); end
        end
        bus_read(0, 17, d);
        checks++;
        if (d !== 32'h0000_0011) begin failures++; $display("FAIL lenerr_w17_kept got %h exp 00000011", d); end
    endtask

    task automatic test_bus();
        logic [31:0] d;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        bus_write(0, 5, 32'hFFFF_FFFF, 4'b0101);
        bus_read(0, 5, d);
        checks++;
        if (d !== 32'h00FF_00FF) begin failures++; $display("FAIL be_write got %h exp 00ff00ff", d); end
        bus_write(0, 5, 32'h0, 4'hF);
        bus_read(0, 32'h1000_0011, d);
        checks++;
        if (d !== 32'h0000_0011) begin failures++; $display("FAIL upper_addr_ignored got %h exp 00000011", d); end
        checks++;
        if (accel_error !== ACC_ERR_NONE) begin failures++; $display("FAIL no_spurious_err got %0d exp 0", accel_error); end
        bus_read(0, 30, d);
        checks += 2;
        if (d !== 32'h0) begin failures++; $display("FAIL bad_addr_rdata got %h exp 0", d); end
        if (accel_error !== ACC_ERR_ADDR) begin failures++; $display("FAIL bad_addr_err got %0d exp %0d", accel_error, ACC_ERR_ADDR); end
    endtask

    task automatic test_contexts();
        logic [31:0] d;
        int cyc;
        load_ctx(1, 32'h1, 32'h0);
        run(1, 32, cyc);
        checks += 2;
        if (cyc !== 25) begin failures++; $display("FAIL ctx1_latency got %0d exp 25", cyc); end
        if (accel_error !== ACC_ERR_NONE) begin failures++; $display("FAIL ctx1_err_cleared got %0d exp 0", accel_error); end
        for (int k = 0; k < 8; k++) begin
            bus_read(1, 16 + k, d);
            checks++;
            if (d !== (32'h8000 << k)) begin failures++; $display("FAIL ctx1_w%0d got %h exp %h", 16 + k, d, 32'h8000 << k); end
        end
        run(0, 8, cyc);
        bus_read(0, 17, d);
        checks++;
        if (d !== 32'h1111_1111) begin failures++; $display("FAIL ctx0_rerun_w17 got %h exp 11111111", d); end
        bus_read(1, 16, d);
        checks++;
        if (d !== 32'h0000_8000) begin failures++; $display("FAIL ctx1_kept_w16 got %h exp 00008000", d); end
        bus_read(1, 0, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL ctx1_kept_w0 got %h exp 1", d); end
    endtask

    task automatic test_busy_access();
        logic [31:0] d;
        acc_error_t exp_err;
        int cyc;
`ifdef ACCEL_BUS_LOCK_EN
        exp_err = ACC_ERR_BUSY;
`else
        exp_err = ACC_ERR_NONE;
`endif
        @(negedge clk); ctx_sel = 0; output_length_byte = 8; start = 1;
        repeat (3) @(posedge clk);
        bus_write(1, 16, 32'hDEAD_BEEF, 4'hF);
        bus_write(0, 1, 32'hDEAD_BEEF, 4'hF);
        checks += 2;
        if (mem_rdata !== 32'h0) begin failures++; $display("FAIL busy_rdata got %h exp 0", mem_rdata); end
        if (accel_error !== exp_err) begin failures++; $display("FAIL busy_err got %0d exp %0d", accel_error, exp_err); end
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL busy_run_done got %b exp 1", done); end
        @(negedge clk); start = 0;
        @(negedge clk);
        bus_read(0, 1, d);
        checks++;
        if (d !== 32'h8888_8888) begin failures++; $display("FAIL busy_write_dropped got %h exp 88888888", d); end
        bus_read(0, 16, d);
        checks++;
        if (d !== 32'h8888_8888) begin failures++; $display("FAIL busy_run_result got %h exp 88888888", d); end
        bus_read(1, 16, d);
        checks++;
        if (d !== 32'h0000_8000) begin failures++; $display("FAIL busy_ctx1_kept got %h exp 00008000", d); end
    endtask

    initial begin
        test_reset();
        test_digest();
        test_partial_length();
        test_len_error();
        test_bus();
        test_contexts();
        test_busy_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
